// File: rtl/serial_tx.sv
// Memory-mapped 8N1 UART transmitter: byte stores at offset 8 are queued in a
// small FIFO and serialized LSB first on txd; offset 0xc reports write-space and idle.
module serial_tx #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        txd
);

    localparam logic [3:0] IO_LB = 4'h3;
    localparam logic [3:0] IO_SB = 4'h6;

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_ZERO   = {CNT_W{1'b0}};
    localparam logic [PTR_W:0]   FULL_COUNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   EMPTY_COUNT = {(PTR_W + 1){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             txd_r;

    logic [7:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    logic       is_write_s;
    logic       is_test_s;
    logic       is_read_s;
    logic       can_write_s;
    logic       fifo_empty_s;
    logic       tx_empty_s;
    logic       push_s;
    logic       pop_s;
    logic [7:0] pop_data_s;
    logic       unused_s;

    assign is_write_s   = (mode == IO_SB) && (addr[3:0] == 4'h8);
    assign is_test_s    = (mode == IO_LB) && (addr[3:0] == 4'hc);
    // No receiver exists, so a data-register load reads zero with no side effect.
    assign is_read_s    = (mode == IO_LB) && (addr[3:0] == 4'h8);
    assign can_write_s  = (count_r != FULL_COUNT);
    assign fifo_empty_s = (count_r == EMPTY_COUNT);
    assign tx_empty_s   = fifo_empty_s && (state_r == ST_IDLE);
    assign push_s       = is_write_s && can_write_s;
    assign pop_data_s   = fifo_mem_r[rd_ptr_r];
    assign unused_s     = ^{addr[31:4], wdata[31:8], is_read_s};

    // Status load data, combinational on the current bus request.
    always_comb begin
        rdata = 32'd0;
        if (is_test_s) begin
            rdata = {24'd0, 5'd0, tx_empty_s, 1'b0, can_write_s};
        end else begin
            rdata = 32'd0;
        end
    end

    // The FSM pops when it leaves IDLE or ends a stop bit with data still queued.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = !fifo_empty_s;
            ST_STOP: pop_s = (baud_cnt_r == BAUD_ZERO) && !fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // TX FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 8'd0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= EMPTY_COUNT;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= wdata[7:0];
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame sequencer; txd is updated together with each state/bit transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= BAUD_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            txd_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_r    <= pop_data_s;
                        baud_cnt_r <= BAUD_RELOAD;
                        txd_r      <= 1'b0;
                        state_r    <= ST_START;
                    end else begin
                        txd_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_cnt_r == BAUD_ZERO) begin
                        baud_cnt_r <= BAUD_RELOAD;
                        bit_idx_r  <= 3'd0;
                        txd_r      <= shift_r[0];
                        state_r    <= ST_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_cnt_r == BAUD_ZERO) begin
                        baud_cnt_r <= BAUD_RELOAD;
                        shift_r    <= {1'b0, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            txd_r   <= 1'b1;
                            state_r <= ST_STOP;
                        end else begin
                            txd_r     <= shift_r[1];
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_cnt_r == BAUD_ZERO) begin
                        if (pop_s) begin
                            shift_r    <= pop_data_s;
                            baud_cnt_r <= BAUD_RELOAD;
                            txd_r      <= 1'b0;
                            state_r    <= ST_START;
                        end else begin
                            txd_r   <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    txd_r   <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign txd = txd_r;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx with BAUD_DIV=4, FIFO_DEPTH=4; a line monitor
// decodes txd frames so each scenario can compare the received bytes.
module tb_serial_tx;

    localparam logic [3:0] IO_NONE = 4'h0;
    localparam logic [3:0] IO_LW   = 4'h1;
    localparam logic [3:0] IO_LB   = 4'h3;
    localparam logic [3:0] IO_SW   = 4'h4;
    localparam logic [3:0] IO_SB   = 4'h6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  mode = 4'h0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        txd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    serial_tx #(.BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .txd   (txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: 4 samples per bit, sampling each bit at its middle.
    logic       mon_busy = 1'b0;
    int         mon_t = 0;
    logic [7:0] mon_byte = 8'd0;
    logic [7:0] rx_q [$];
    int         start_q [$];
    int         frame_err = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy = 1'b0;
            mon_t    = 0;
        end else if (!mon_busy) begin
            if (txd === 1'b0) begin
                mon_busy = 1'b1;
                mon_t    = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_t = mon_t + 1;
            if (mon_t == 2 && txd !== 1'b0) begin
                frame_err = frame_err + 1;
                mon_busy  = 1'b0;
            end else if (mon_t >= 6 && mon_t <= 34 && (mon_t % 4) == 2) begin
                mon_byte[(mon_t - 6) / 4] = txd;
            end else if (mon_t == 38) begin
                if (txd !== 1'b1) frame_err = frame_err + 1;
                rx_q.push_back(mon_byte);
                mon_busy = 1'b0;
            end
        end
    end

    task automatic drive(input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
        mode  = m;
        addr  = a;
        wdata = d;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        start_q.delete();
        frame_err = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(IO_NONE, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin
            errors++;
            $display("FAIL reset_txd: txd=%b expected 1", txd);
        end
        rst_n = 1'b1;
        drive(IO_LB, 32'hc, 32'd0);
        #1;
        checks++;
        if (rdata !== 32'h5) begin
            errors++;
            $display("FAIL reset_status: rdata=%h expected 00000005", rdata);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle_txd cycle %0d: txd=%b expected 1", i, txd);
            end
        end
        drive(IO_NONE, 32'd0, 32'd0);
        clear_rx();
    endtask

    task automatic test_single_byte();
        logic [9:0] fr;
        fr = {1'b1, 8'h55, 1'b0};
        @(negedge clk);
        drive(IO_SB, 32'h8, 32'h55);
        @(posedge clk);
        @(negedge clk);
        drive(IO_LB, 32'hc, 32'd0);
        #1;
        checks++;
        if (rdata !== 32'h1) begin
            errors++;
            $display("FAIL single_status_after_store: rdata=%h expected 00000001", rdata);
        end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (txd !== fr[(k - 1) / 4]) begin
                errors++;
                $display("FAIL single_wave cycle %0d: txd=%b expected %b", k, txd, fr[(k - 1) / 4]);
            end
            if (k == 20) begin
                checks++;
                if (rdata !== 32'h1) begin
                    errors++;
                    $display("FAIL single_status_mid: rdata=%h expected 00000001", rdata);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdata !== 32'h5) begin
            errors++;
            $display("FAIL single_status_after: rdata=%h expected 00000005", rdata);
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h55 || frame_err != 0) begin
            errors++;
            $display("FAIL single_rx: got %0d bytes (first %h, frame errors %0d) expected one byte 55",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, frame_err);
        end
        drive(IO_NONE, 32'd0, 32'd0);
        clear_rx();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        int w;
        exp_b = '{8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(IO_SB, 32'h8, {24'd0, exp_b[i]});
            @(posedge clk);
        end
        @(negedge clk);
        drive(IO_LB, 32'hc, 32'd0);
        w = 0;
        while (rx_q.size() < 3 && w < 300) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (rx_q.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d bytes expected 3", rx_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < rx_q.size()) begin
                checks++;
                if (rx_q[i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[i], exp_b[i]);
                end
            end
        end
        if (start_q.size() >= 3) begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (start_q[i] - start_q[i - 1] != 40) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles expected 40", i, start_q[i] - start_q[i - 1]);
                end
            end
        end
        checks++;
        if (frame_err != 0) begin
            errors++;
            $display("FAIL b2b_framing: got %0d frame errors expected 0", frame_err);
        end
        w = 0;
        while (rdata !== 32'h5 && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (rdata !== 32'h5) begin
            errors++;
            $display("FAIL b2b_idle: rdata=%h expected 00000005", rdata);
        end
        drive(IO_NONE, 32'd0, 32'd0);
        clear_rx();
    endtask

    task automatic test_full_fifo();
        int w;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(IO_SB, 32'h8, 32'h30 + i);
            @(posedge clk);
        end
        @(negedge clk);
        drive(IO_LB, 32'hc, 32'd0);
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL full_status: rdata=%h expected 00000000", rdata);
        end
        w = 0;
        while (rx_q.size() < 5 && w < 400) begin
            @(negedge clk);
            w++;
        end
        repeat (60) @(negedge clk);
        checks++;
        if (rx_q.size() != 5) begin
            errors++;
            $display("FAIL full_count: got %0d bytes expected 5", rx_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) begin
                checks++;
                if (rx_q[i] !== 8'(8'h30 + i)) begin
                    errors++;
                    $display("FAIL full_byte%0d: got %h expected %h", i, rx_q[i], 8'(8'h30 + i));
                end
            end
        end
        checks++;
        if (rdata !== 32'h5) begin
            errors++;
            $display("FAIL full_idle: rdata=%h expected 00000005", rdata);
        end
        drive(IO_NONE, 32'd0, 32'd0);
        clear_rx();
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        drive(IO_SB, 32'h8, 32'hA5);
        @(posedge clk);
        @(negedge clk);
        drive(IO_SB, 32'h8, 32'h11);
        @(posedge clk);
        @(negedge clk);
        drive(IO_SB, 32'h8, 32'h22);
        @(posedge clk);
        @(negedge clk);
        drive(IO_NONE, 32'd0, 32'd0);
        // Store of A5 was at edge N; N+18 lies inside data bit 3 (a zero).
        repeat (16) @(posedge clk);
        #2;
        checks++;
        if (txd !== 1'b0) begin
            errors++;
            $display("FAIL midreset_bit3: txd=%b expected 0", txd);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1) begin
            errors++;
            $display("FAIL midreset_async: txd=%b expected 1", txd);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_rx();
        repeat (100) @(negedge clk);
        checks++;
        if (rx_q.size() != 0 || start_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d bytes, %0d starts expected 0", rx_q.size(), start_q.size());
        end
        drive(IO_LB, 32'hc, 32'd0);
        #1;
        checks++;
        if (rdata !== 32'h5) begin
            errors++;
            $display("FAIL midreset_status: rdata=%h expected 00000005", rdata);
        end
        drive(IO_NONE, 32'd0, 32'd0);
    endtask

    task automatic test_decode_isolation();
        int bad;
        @(negedge clk);
        drive(IO_LB, 32'h8, 32'd0);
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL decode_lb8: rdata=%h expected 00000000", rdata);
        end
        drive(IO_LW, 32'hc, 32'd0);
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL decode_lwc: rdata=%h expected 00000000", rdata);
        end
        @(posedge clk);
        @(negedge clk);
        drive(IO_SB, 32'h4, 32'h77);
        @(posedge clk);
        @(negedge clk);
        drive(IO_SW, 32'h8, 32'h66);
        @(posedge clk);
        @(negedge clk);
        drive(IO_LB, 32'hc, 32'd0);
        #1;
        checks++;
        if (rdata !== 32'h5) begin
            errors++;
            $display("FAIL decode_status: rdata=%h expected 00000005", rdata);
        end
        drive(IO_NONE, 32'd0, 32'd0);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || start_q.size() != 0) begin
            errors++;
            $display("FAIL decode_txd_idle: %0d low samples, %0d starts expected 0", bad, start_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_full_fifo();
        test_reset_mid_frame();
        test_decode_isolation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
